// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide sequencer.
// Op codes match the decoder's mult/div field.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per cycle.
// quotient/remainder are valid in the cycle valid is high.
module div_radix2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid
);

    logic        run_q, run_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic [31:0] dv_q, dv_d;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] q_step;
    logic [31:0] r_step;

    // rem < divisor always, so the restored result fits in 32 bits
    always_comb begin
        shifted = {r_q, q_q[31]};
        fits    = shifted >= {1'b0, dv_q};
        r_step  = fits ? (shifted[31:0] - dv_q) : shifted[31:0];
        q_step  = {q_q[30:0], fits};
    end

    assign quotient  = q_step;
    assign remainder = r_step;
    assign valid     = run_q && (cnt_q == 5'd31);

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        q_d   = q_q;
        r_d   = r_q;
        dv_d  = dv_q;
        if (cancel) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            q_d   = dividend;
            r_d   = '0;
            dv_d  = divisor;
        end else if (run_q) begin
            q_d   = q_step;
            r_d   = r_step;
            cnt_d = cnt_q + 5'd1;
            if (valid) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dv_q  <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
            r_q   <= r_d;
            dv_q  <= dv_d;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: stalls EX until the result is ready,
// then pulses done with HI/LO write data for one cycle.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall_o,
    output logic        done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy
);

    localparam logic [2:0] MUL_LAST = 3'(MUL_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        qsign_q, qsign_d;
    logic        rsign_q, rsign_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        is_div;
    logic        is_signed;
    logic        b_zero;
    logic        mul_last;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic        div_start;
    logic        div_valid;
    logic [31:0] div_q;
    logic [31:0] div_r;

    assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign b_zero    = (b == '0);
    assign accept    = (state_q == S_IDLE) && start && !flush;
    assign a_in      = is_signed ? abs32(a) : a;
    assign b_in      = is_signed ? abs32(b) : b;
    assign div_start = accept && is_div && !b_zero;
    assign mul_last  = (state_q == S_MUL) && (cnt_q == MUL_LAST);

    // Operands are held as magnitudes; the captured sign restores the result
    assign prod_mag  = {32'b0, a_q} * {32'b0, b_q};
    assign prod      = qsign_q ? -prod_mag : prod_mag;

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .cancel    (flush),
        .dividend  (a_in),
        .divisor   (b_in),
        .quotient  (div_q),
        .remainder (div_r),
        .valid     (div_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_div)     state_d = S_MUL;
                    else if (b_zero) state_d = S_DONE;
                    else             state_d = S_DIV;
                end
            end
            S_MUL:   if (mul_last) state_d = S_DONE;
            S_DIV:   if (div_valid) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // hi_o/lo_o show the pending result only while done is asserted
    always_comb begin
        stall_o = 1'b0;
        done    = 1'b0;
        busy    = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE:       stall_o = accept;
            S_MUL, S_DIV: stall_o = !flush;
            S_DONE:       done = !flush;
            default:      ;
        endcase
        if (rst) begin
            stall_o = 1'b0;
            done    = 1'b0;
        end
        hi_o = done ? res_hi_q : hi_q;
        lo_o = done ? res_lo_q : lo_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (accept) begin
            a_d     = a_in;
            b_d     = b_in;
            qsign_d = is_signed & (a[31] ^ b[31]);
            rsign_d = is_signed & a[31];
            cnt_d   = '0;
            if (is_div && b_zero) begin
                res_lo_d = DIVZ_LO;
                res_hi_d = a;
            end
        end
        if (state_q == S_MUL) begin
            cnt_d = cnt_q + 3'd1;
            if (mul_last) {res_hi_d, res_lo_d} = prod;
        end
        if ((state_q == S_DIV) && div_valid) begin
            res_lo_d = qsign_q ? -div_q : div_q;
            res_hi_d = rsign_q ? -div_r : div_r;
        end
        if (done) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed and random ops against an arithmetic model,
// including flush/reset cancellation and divide-by-zero.
module tb_muldiv_ctrl;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        stall_o;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .stall_o (stall_o),
        .done    (done),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected results straight from 64-bit integer arithmetic
    task automatic model(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] eh,
                         output logic [31:0] el, output int lat);
        longint sx, sy, q, r, p;
        logic [63:0] pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o[1]) begin
            if (!o[0]) begin
                p  = sx * sy;
                pu = p;
            end else begin
                pu = {32'b0, x} * {32'b0, y};
            end
            eh  = pu[63:32];
            el  = pu[31:0];
            lat = MC + 1;
        end else if (y == 0) begin
            eh  = x;
            el  = 32'hFFFF_FFFF;
            lat = 1;
        end else if (!o[0]) begin
            q   = sx / sy;
            r   = sx % sy;
            el  = q[31:0];
            eh  = r[31:0];
            lat = 33;
        end else begin
            el  = x / y;
            eh  = x % y;
            lat = 33;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int cut_at,
                          input bit by_rst);
        logic [31:0] eh, el;
        int lat, cyc;
        bit fin;
        model(o, x, y, eh, el, lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        cyc = 0;
        fin = 0;
        while (!fin) begin
            if (cyc == cut_at) begin
                if (by_rst) rst = 1'b1;
                else flush = 1'b1;
                @(negedge clk);
                chk("cut_stall", 64'(stall_o), 64'd0);
                chk("cut_done", 64'(done), 64'd0);
                chk("cut_hi", 64'(hi_o), 64'(last_hi));
                chk("cut_lo", 64'(lo_o), 64'(last_lo));
                @(posedge clk); #1;
                rst = 1'b0; flush = 1'b0; start = 1'b0;
                if (by_rst) begin
                    last_hi = '0;
                    last_lo = '0;
                end
                @(negedge clk);
                chk("cut_busy", 64'(busy), 64'd0);
                chk("cut_hi_after", 64'(hi_o), 64'(last_hi));
                chk("cut_lo_after", 64'(lo_o), 64'(last_lo));
                fin = 1;
            end else begin
                @(negedge clk);
                if (done === 1'b1) begin
                    chk("latency", 64'(cyc), 64'(lat));
                    chk("done_stall", 64'(stall_o), 64'd0);
                    chk("done_hi", 64'(hi_o), 64'(eh));
                    chk("done_lo", 64'(lo_o), 64'(el));
                    chk("done_busy", 64'(busy), 64'd1);
                    last_hi = eh;
                    last_lo = el;
                    @(posedge clk); #1;
                    start = 1'b0;
                    @(negedge clk);
                    chk("idle_busy", 64'(busy), 64'd0);
                    chk("idle_done", 64'(done), 64'd0);
                    chk("hold_hi", 64'(hi_o), 64'(last_hi));
                    chk("hold_lo", 64'(lo_o), 64'(last_lo));
                    fin = 1;
                end else if (cyc >= lat) begin
                    chk("done_by_latency", 64'(done), 64'd1);
                    @(posedge clk); #1;
                    start = 1'b0; flush = 1'b1;
                    @(posedge clk); #1;
                    flush = 1'b0;
                    fin = 1;
                end else begin
                    chk("run_stall", 64'(stall_o), 64'd1);
                    chk("run_busy", 64'(busy), 64'(cyc != 0));
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int pick;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, -1, 1'b0);
        run_op(2'b11, 32'h0000_1234, 32'd0, -1, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, -1, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        run_op(2'b00, 32'd6, 32'd7, -1, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);
        run_op(2'b00, 32'd6, 32'd7, -1, 1'b0);
        run_op(2'b01, 32'd9, 32'd9, 3, 1'b0);
        run_op(2'b00, 32'd9, 32'd9, 0, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            pick = $urandom_range(0, 7);
            unique case (pick)
                0:       ry = '0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'($urandom_range(1, 15));
                3:       ry = 32'h8000_0000;
                default: ry = $urandom;
            endcase
            run_op(ro, rx, ry, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
